// File: rtl/div32_pkg.sv
// Shared types and constants for the sequential 32-bit divider.
// Optional signed support is enabled by the DIV32_SEQ_SIGNED_EN macro in div32_seq.
package div32_pkg;

    localparam int          WIDTH     = 32;
    localparam int          CNT_W     = 6;
    localparam logic [31:0] DBZ_QUOT  = 32'hFFFF_FFFF;
    localparam logic [5:0]  LAST_ITER = 6'd31;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        NEG_IN  = 3'd1,
        CALC    = 3'd2,
        NEG_OUT = 3'd3,
        FIN     = 3'd4
    } state_t;

    // Shift the remainder left by one, pulling in the next dividend bit.
    function automatic logic [31:0] shift_in(input logic [31:0] r, input logic [31:0] q);
        shift_in = {r[30:0], q[31]};
    endfunction

endpackage

// File: rtl/addsub32.sv
// Fixed 32-bit adder/subtractor; co is the carry out (for sub=1, co=1 means no borrow).
module addsub32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic [31:0] res,
    output logic        co
);

    logic [32:0] sum_s;
    logic [31:0] b_eff_s;

    // Two's complement subtract is a + ~b + 1.
    always_comb begin
        b_eff_s = sub ? ~b : b;
        sum_s   = {1'b0, a} + {1'b0, b_eff_s} + {32'd0, sub};
        res     = sum_s[31:0];
        co      = sum_s[32];
    end

endmodule

// File: rtl/div32_seq.sv
// Multi-cycle restoring divider: one quotient bit per cycle through a single addsub32.
// Define DIV32_SEQ_SIGNED_EN to add the sgn input and the NEG_IN/NEG_OUT sign-fixup states.
module div32_seq #(
    parameter int          WIDTH    = 32,
    parameter int          CNT_W    = 6,
    parameter logic [31:0] DBZ_QUOT = 32'hFFFF_FFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef DIV32_SEQ_SIGNED_EN
    input  logic             sgn,
`endif
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem
);

    import div32_pkg::*;

    state_t             state_r, state_s;
    logic [WIDTH-1:0]   q_r, q_s;
    logic [WIDTH-1:0]   r_r, r_s;
    logic [WIDTH-1:0]   d_r, d_s;
    logic [CNT_W-1:0]   count_r, count_s;
    logic               dbz_r, dbz_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;
    logic [WIDTH-1:0]   quot_r, quot_s;
    logic [WIDTH-1:0]   rem_r, rem_s;

    logic [WIDTH-1:0]   as_a_s;
    logic [WIDTH-1:0]   as_b_s;
    logic [WIDTH-1:0]   as_res_s;
    logic               as_co_s;
    logic [WIDTH-1:0]   shift_s;
    logic               qb_s;

`ifdef DIV32_SEQ_SIGNED_EN
    logic               signed_r, signed_s;
    logic               neg_dvd_r, neg_dvd_s;
    logic               neg_dvs_r, neg_dvs_s;
`endif

    // The only arithmetic resource; always subtracting.
    addsub32 u_addsub (
        .a   (as_a_s),
        .b   (as_b_s),
        .sub (1'b1),
        .res (as_res_s),
        .co  (as_co_s)
    );

    // Restoring step: quotient bit is set when the shifted remainder covers the divisor,
    // including the case where the bit shifted out of r makes it exceed 2^32.
    always_comb begin
        shift_s = shift_in(r_r, q_r);
        qb_s    = as_co_s | r_r[WIDTH-1];
    end

    // Next-state, datapath and output-register logic.
    always_comb begin
        state_s = state_r;
        q_s     = q_r;
        r_s     = r_r;
        d_s     = d_r;
        count_s = count_r;
        dbz_s   = dbz_r;
        quot_s  = quot_r;
        rem_s   = rem_r;
        done_s  = 1'b0;
        busy_s  = (state_r != IDLE);
        as_a_s  = shift_s;
        as_b_s  = d_r;
`ifdef DIV32_SEQ_SIGNED_EN
        signed_s  = signed_r;
        neg_dvd_s = neg_dvd_r;
        neg_dvs_s = neg_dvs_r;
`endif

        case (state_r)
            IDLE: begin
                if (start) begin
                    q_s     = dividend;
                    d_s     = divisor;
                    r_s     = {WIDTH{1'b0}};
                    count_s = {CNT_W{1'b0}};
                    dbz_s   = (divisor == {WIDTH{1'b0}});
`ifdef DIV32_SEQ_SIGNED_EN
                    signed_s  = sgn & (divisor != {WIDTH{1'b0}});
                    neg_dvd_s = sgn & dividend[WIDTH-1];
                    neg_dvs_s = sgn & divisor[WIDTH-1];
`endif
                    if (divisor == {WIDTH{1'b0}}) begin
                        // One held CALC cycle gives the two-edge divide-by-zero latency.
                        count_s = LAST_ITER;
                        state_s = CALC;
                    end else begin
`ifdef DIV32_SEQ_SIGNED_EN
                        state_s = sgn ? NEG_IN : CALC;
`else
                        state_s = CALC;
`endif
                    end
                end else begin
                    state_s = IDLE;
                end
            end

`ifdef DIV32_SEQ_SIGNED_EN
            NEG_IN: begin
                // Cycle 0 takes |dividend|, cycle 1 takes |divisor|; both cycles always spent.
                as_a_s = {WIDTH{1'b0}};
                if (count_r[0] == 1'b0) begin
                    as_b_s  = q_r;
                    if (neg_dvd_r) begin
                        q_s = as_res_s;
                    end else begin
                        q_s = q_r;
                    end
                    count_s = count_r + 6'd1;
                end else begin
                    as_b_s  = d_r;
                    if (neg_dvs_r) begin
                        d_s = as_res_s;
                    end else begin
                        d_s = d_r;
                    end
                    count_s = {CNT_W{1'b0}};
                    state_s = CALC;
                end
            end

            NEG_OUT: begin
                // Cycle 0 fixes the quotient sign, cycle 1 the remainder sign.
                as_a_s = {WIDTH{1'b0}};
                if (count_r[0] == 1'b0) begin
                    as_b_s  = q_r;
                    if (neg_dvd_r ^ neg_dvs_r) begin
                        q_s = as_res_s;
                    end else begin
                        q_s = q_r;
                    end
                    count_s = count_r + 6'd1;
                end else begin
                    as_b_s  = r_r;
                    if (neg_dvd_r) begin
                        r_s = as_res_s;
                    end else begin
                        r_s = r_r;
                    end
                    count_s = {CNT_W{1'b0}};
                    state_s = FIN;
                end
            end
`endif

            CALC: begin
                as_a_s = shift_s;
                as_b_s = d_r;
                if (!dbz_r) begin
                    r_s = qb_s ? as_res_s : shift_s;
                    q_s = {q_r[WIDTH-2:0], qb_s};
                end else begin
                    // Hold the captured dividend so it can be returned as the remainder.
                    r_s = r_r;
                    q_s = q_r;
                end
                if (count_r == LAST_ITER) begin
                    count_s = {CNT_W{1'b0}};
`ifdef DIV32_SEQ_SIGNED_EN
                    state_s = signed_r ? NEG_OUT : FIN;
`else
                    state_s = FIN;
`endif
                end else begin
                    count_s = count_r + 6'd1;
                    state_s = CALC;
                end
            end

            FIN: begin
                if (dbz_r) begin
                    quot_s = DBZ_QUOT;
                    rem_s  = q_r;
                end else begin
                    quot_s = q_r;
                    rem_s  = r_r;
                end
                done_s  = 1'b1;
                state_s = IDLE;
            end

            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            q_r     <= {WIDTH{1'b0}};
            r_r     <= {WIDTH{1'b0}};
            d_r     <= {WIDTH{1'b0}};
            count_r <= {CNT_W{1'b0}};
            dbz_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            quot_r  <= {WIDTH{1'b0}};
            rem_r   <= {WIDTH{1'b0}};
        end else begin
            state_r <= state_s;
            q_r     <= q_s;
            r_r     <= r_s;
            d_r     <= d_s;
            count_r <= count_s;
            dbz_r   <= dbz_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            quot_r  <= quot_s;
            rem_r   <= rem_s;
        end
    end

`ifdef DIV32_SEQ_SIGNED_EN
    // Sign bookkeeping registers for the signed mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            signed_r  <= 1'b0;
            neg_dvd_r <= 1'b0;
            neg_dvs_r <= 1'b0;
        end else begin
            signed_r  <= signed_s;
            neg_dvd_r <= neg_dvd_s;
            neg_dvs_r <= neg_dvs_s;
        end
    end
`endif

    assign busy = busy_r;
    assign done = done_r;
    assign dbz  = dbz_r;
    assign quot = quot_r;
    assign rem  = rem_r;

endmodule

// File: tb/tb_div32_seq.sv
// Directed scoreboard bench for div32_seq; also covers DIV32_SEQ_SIGNED_EN when defined.
module tb_div32_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sgn;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic        dbz;
    logic [31:0] quot;
    logic [31:0] rem;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    div32_seq dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
`ifdef DIV32_SEQ_SIGNED_EN
        .sgn      (sgn),
`endif
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .dbz      (dbz),
        .quot     (quot),
        .rem      (rem)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_t e;
        if (b == 32'd0) begin
            e.q = 32'hFFFF_FFFF; e.r = a; e.z = 1'b1; e.lat = 2;
        end else if (s) begin
            e.z = 1'b0; e.lat = 37;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                e.q = 32'h8000_0000; e.r = 32'd0;
            end else begin
                e.q = $signed(a) / $signed(b);
                e.r = $signed(a) % $signed(b);
            end
        end else begin
            e.q = a / b; e.r = a % b; e.z = 1'b0; e.lat = 33;
        end
        return e;
    endfunction

    task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input bit inject);
        exp_t e;
        int   cyc;
        int   bcnt;
        bit   seen;
        e = model(a, b, s);
        sb.push_back(e);
        start = 1'b1; dividend = a; divisor = b; sgn = s;
        tick();
        start = 1'b0; dividend = $urandom; divisor = $urandom;
        check({tag, "_dbz_at_accept"}, {31'd0, dbz}, {31'd0, e.z});
        cyc = 0; bcnt = 0; seen = 1'b0;
        while (!seen && cyc < 100) begin
            if (inject && cyc == 10) begin
                start = 1'b1; dividend = 32'd3; divisor = 32'd2;
            end
            tick();
            start = 1'b0;
            cyc++;
            if (busy) bcnt++;
            if (done) seen = 1'b1;
        end
        e = sb.pop_front();
        check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        check({tag, "_latency"}, cyc, e.lat);
        check({tag, "_busy_cycles"}, bcnt, e.lat);
        check({tag, "_quot"}, quot, e.q);
        check({tag, "_rem"}, rem, e.r);
        check({tag, "_dbz"}, {31'd0, dbz}, {31'd0, e.z});
    endtask

    initial begin
        int dcnt;
        rst = 1'b1; start = 1'b0; sgn = 1'b0; dividend = 32'd0; divisor = 32'd0;

        // Reset and idle.
        repeat (3) tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("idle_busy", {31'd0, busy}, 32'd0);
            check("idle_done", {31'd0, done}, 32'd0);
            check("idle_dbz", {31'd0, dbz}, 32'd0);
            check("idle_quot", quot, 32'd0);
            check("idle_rem", rem, 32'd0);
            tick();
        end

        // Basic divide and result hold.
        do_div("basic", 32'd100, 32'd7, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_done", {31'd0, done}, 32'd0);
            check("hold_quot", quot, 32'd14);
            check("hold_rem", rem, 32'd2);
        end

        // MSB-overflow path and edge values.
        do_div("msb", 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 1'b0);
        do_div("div1", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        do_div("small", 32'd5, 32'd9, 1'b0, 1'b0);
        do_div("allones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);

        // Divide-by-zero then a normal divide back-to-back.
        do_div("dbz", 32'h1234_5678, 32'd0, 1'b0, 1'b0);
        do_div("after_dbz", 32'd1000, 32'd10, 1'b0, 1'b0);

        // Start while busy is ignored.
        do_div("busy_start", 32'd500, 32'd3, 1'b0, 1'b1);

        // Reset mid-operation aborts.
        start = 1'b1; dividend = 32'd777; divisor = 32'd5;
        tick();
        start = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_quot", quot, 32'd0);
        check("abort_rem", rem, 32'd0);
        check("abort_dbz", {31'd0, dbz}, 32'd0);
        rst = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) dcnt++;
        end
        check("abort_no_done", dcnt, 0);
        do_div("restart", 32'd777, 32'd5, 1'b0, 1'b0);

`ifdef DIV32_SEQ_SIGNED_EN
        do_div("s_negdvd", 32'hFFFF_FF9C, 32'd7, 1'b1, 1'b0);
        do_div("s_negdvs", 32'd100, 32'hFFFF_FFF9, 1'b1, 1'b0);
        do_div("s_bothneg", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 1'b0);
        do_div("s_pos", 32'd100, 32'd7, 1'b1, 1'b0);
        do_div("s_minint", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        do_div("s_dbz", 32'hFFFF_FF9C, 32'd0, 1'b1, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
